// File: rtl/pwm_multichannel_peripheral.sv
// N-channel PWM generator: shared prescaler and period counter (edge or centre aligned),
// per-channel double-buffered duty registers and output/PWM enables.
module pwm_multichannel_peripheral #(
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     en_out,
  input  logic [NUM_CH-1:0]     en_pwm,
  input  logic [CNT_W-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  center_mode,
  input  logic                  duty_wr,
  input  logic [CH_W-1:0]       duty_wr_ch,
  input  logic [CNT_W-1:0]      duty_wr_data,
  output logic [NUM_CH-1:0]     out,
  output logic                  period_start,
  output logic [CNT_W-1:0]      cnt_out
);

  logic [PRESCALE_W-1:0] presc_cnt;
  logic                  tick;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  dir;
  logic                  dir_nxt;
  logic                  mode_active;
  logic                  boundary;
  logic                  wr_valid;
  logic [NUM_CH-1:0]     wr_sel;
  logic [NUM_CH-1:0]     raw;
  logic [CNT_W-1:0]      shadow_duty [NUM_CH];
  logic [CNT_W-1:0]      active_duty [NUM_CH];

  assign tick    = (presc_cnt >= prescale);
  assign cnt_out = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_W'(1);
    end
  end

  // Next-count logic; '>=' comparisons absorb a live period decrease in one tick.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (period == '0) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (!mode_active) begin
      cnt_nxt = (cnt >= period) ? '0 : cnt + CNT_W'(1);
      dir_nxt = 1'b0;
    end else if (!dir) begin
      if (cnt >= period) begin
        cnt_nxt = cnt - CNT_W'(1);
        dir_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      cnt_nxt = cnt - CNT_W'(1);
    end
    if (cnt_nxt == '0) begin
      dir_nxt = 1'b0;
    end
  end

  assign boundary = tick && (cnt_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir          <= 1'b0;
      mode_active  <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
      if (boundary) begin
        mode_active <= center_mode;
      end
      period_start <= boundary;
    end
  end

  assign wr_valid = duty_wr && ({1'b0, duty_wr_ch} < (CH_W+1)'(NUM_CH));

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_valid && (duty_wr_ch == CH_W'(i));
    end
  end

  // A write landing on a boundary goes straight into the active register as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_duty[i] <= '0;
        active_duty[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          shadow_duty[i] <= duty_wr_data;
        end
        if (boundary) begin
          active_duty[i] <= wr_sel[i] ? duty_wr_data : shadow_duty[i];
        end
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      raw[i] = (cnt < active_duty[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= en_out & (~en_pwm | raw);
    end
  end

endmodule

// File: tb/tb_pwm_multichannel_peripheral.sv
// Directed bench for pwm_multichannel_peripheral: edge/centre counting, duty buffering,
// limits, prescaler, ignored writes and asynchronous reset.
module tb_pwm_multichannel_peripheral;

  localparam int NUM_CH     = 6;
  localparam int CNT_W      = 8;
  localparam int PRESCALE_W = 8;
  localparam int CH_W       = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_CH-1:0]     en_out;
  logic [NUM_CH-1:0]     en_pwm;
  logic [CNT_W-1:0]      period;
  logic [PRESCALE_W-1:0] prescale;
  logic                  center_mode;
  logic                  duty_wr;
  logic [CH_W-1:0]       duty_wr_ch;
  logic [CNT_W-1:0]      duty_wr_data;
  logic [NUM_CH-1:0]     out;
  logic                  period_start;
  logic [CNT_W-1:0]      cnt_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_multichannel_peripheral #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .PRESCALE_W(PRESCALE_W),
    .CH_W      (CH_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_out      (en_out),
    .en_pwm      (en_pwm),
    .period      (period),
    .prescale    (prescale),
    .center_mode (center_mode),
    .duty_wr     (duty_wr),
    .duty_wr_ch  (duty_wr_ch),
    .duty_wr_data(duty_wr_data),
    .out         (out),
    .period_start(period_start),
    .cnt_out     (cnt_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
    duty_wr      = 1'b1;
    duty_wr_ch   = ch;
    duty_wr_data = d;
    step();
    duty_wr      = 1'b0;
  endtask

  task automatic wait_ps(input string tag, input int budget);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = (period_start === 1'b1);
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic capture(input int n, output logic [63:0] ov, output logic [63:0] pv);
    ov = '0;
    pv = '0;
    for (int i = 0; i < n; i++) begin
      ov[i] = out[0];
      pv[i] = period_start;
      step();
    end
  endtask

  task automatic count_high(input int n, input int ch, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (out[ch] === 1'b1) hi++;
      step();
    end
  endtask

  int unsigned watchdog_ns = 200000;
  initial begin
    #(watchdog_ns);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ov, pv;
    logic [NUM_CH-1:0] orv;
    int hi, n;
    int exp_c [17] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};

    rst_n = 1'b0; en_out = '0; en_pwm = '0; period = 8'd9; prescale = '0;
    center_mode = 1'b0; duty_wr = 1'b0; duty_wr_ch = '0; duty_wr_data = '0;
    #1;
    repeat (3) step();
    check("rst_out", 64'(out), 64'd0);
    check("rst_cnt", 64'(cnt_out), 64'd0);
    check("rst_ps", 64'(period_start), 64'd0);

    // Edge mode, duty 3 of period 10
    rst_n = 1'b1; en_out = 6'h01; en_pwm = 6'h01;
    write_duty(3'd0, 8'd3);
    wait_ps("t1_ps0", 30);
    wait_ps("t1_ps1", 30);
    check("t1_cnt0", 64'(cnt_out), 64'd0);
    capture(20, ov, pv);
    check("t1_out_pattern", ov, 64'h0380E);
    check("t1_ps_pattern", pv, 64'h00401);

    // Limits at period 254
    period = 8'd254;
    write_duty(3'd0, 8'd0);
    wait_ps("t2_ps0", 300);
    count_high(255, 0, hi);
    check("t2_duty0_high", 64'(hi), 64'd0);
    en_pwm = 6'h00; step();
    check("t2_pwm_off", 64'(out[0]), 64'd1);
    en_out = 6'h00; step();
    check("t2_out_off", 64'(out[0]), 64'd0);
    en_out = 6'h01; en_pwm = 6'h01; step();
    check("t2_duty0_back", 64'(out[0]), 64'd0);
    write_duty(3'd0, 8'd255);
    wait_ps("t2_ps1", 300);
    step();
    count_high(255, 0, hi);
    check("t2_duty255_high", 64'(hi), 64'd255);
    en_out = 6'h00; step();
    check("t2_out_off_255", 64'(out[0]), 64'd0);
    en_out = 6'h01;

    // Shadow buffering and boundary write-through
    period = 8'd9;
    write_duty(3'd0, 8'd3);
    wait_ps("t3_ps0", 30);
    wait_ps("t3_ps1", 30);
    capture(5, ov, pv);
    check("t3_pre_pattern", ov, 64'h0E);
    check("t3_cnt5", 64'(cnt_out), 64'd5);
    write_duty(3'd0, 8'd7);
    capture(14, ov, pv);
    check("t3_shadow_out", ov, 64'hFE0);
    check("t3_shadow_ps", pv, 64'h010);
    repeat (9) step();
    check("t3_cnt9", 64'(cnt_out), 64'd9);
    write_duty(3'd0, 8'd2);
    check("t3_wt_ps", 64'(period_start), 64'd1);
    capture(10, ov, pv);
    check("t3_wt_out", ov, 64'h006);

    // Centre-aligned, period 4, duty 2
    center_mode = 1'b1; period = 8'd4;
    write_duty(3'd0, 8'd2);
    wait_ps("t4_ps0", 20);
    ov = '0; pv = '0;
    for (int j = 0; j < 17; j++) begin
      if (j < 9) check($sformatf("t4_cnt%0d", j), 64'(cnt_out), 64'(exp_c[j]));
      ov[j] = out[0];
      pv[j] = period_start;
      step();
    end
    check("t4_out_pattern", ov & ~64'h1, 64'h10706);
    check("t4_ps_pattern", pv, 64'h10101);

    // Prescaler 3, period 9, back to edge mode
    center_mode = 1'b0; prescale = 8'd3; period = 8'd9;
    wait_ps("t5_ps0", 150);
    n = 0;
    for (int j = 1; j <= 100; j++) begin
      step();
      if (j == 3) check("t5_cnt_off3", 64'(cnt_out), 64'd0);
      if (j == 4) check("t5_cnt_off4", 64'(cnt_out), 64'd1);
      if (j == 8) check("t5_cnt_off8", 64'(cnt_out), 64'd2);
      if (period_start === 1'b1) begin
        n = j;
        break;
      end
    end
    check("t5_period_len", 64'(n), 64'd40);
    en_out = 6'h3F; en_pwm = 6'h3F;
    write_duty(3'd6, 8'd9);
    wait_ps("t5_ps1", 100);
    wait_ps("t5_ps2", 100);
    hi = 0; orv = '0;
    for (int j = 0; j < 40; j++) begin
      if (out[0] === 1'b1) hi++;
      orv = orv | out;
      step();
    end
    check("t5_ignored_ch0", 64'(hi), 64'd8);
    check("t5_ignored_others", 64'(orv[5:1]), 64'd0);

    // Asynchronous reset mid-run
    prescale = 8'd0;
    write_duty(3'd0, 8'd8);
    write_duty(3'd1, 8'd8);
    wait_ps("t6_ps0", 60);
    wait_ps("t6_ps1", 30);
    repeat (6) step();
    check("t6_cnt6", 64'(cnt_out), 64'd6);
    check("t6_out_pre", 64'(out), 64'h03);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out", 64'(out), 64'd0);
    check("t6_rst_cnt", 64'(cnt_out), 64'd0);
    check("t6_rst_ps", 64'(period_start), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_restart_cnt", 64'(cnt_out), 64'd1);
    orv = '0;
    for (int j = 0; j < 25; j++) begin
      orv = orv | out;
      step();
    end
    check("t6_out_low", 64'(orv), 64'd0);
    write_duty(3'd0, 8'd4);
    wait_ps("t6_ps2", 30);
    capture(10, ov, pv);
    check("t6_new_duty", ov, 64'h1E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
